// File: rtl/pattern_match_pkg.sv
// Shared types and default sizes for the configurable serial pattern detector.
package pattern_match_pkg;

    localparam int PW_DEF = 8;
    localparam int CW_DEF = 8;
    localparam int LW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_match_ctrl_window.sv
// Serial history window for pattern_match_ctrl: shift register, fill counter and
// length-masked compare. match is evaluated on the value the history is about to take.
import pattern_match_pkg::*;

module pattern_window #(
    parameter int PW = PW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift,
    input  logic          in,
    input  logic          clear,
    input  logic          clear_fill,
    input  logic [LW-1:0] len,
    input  logic [PW-1:0] pattern,
    output logic          match
);

    localparam logic [LW-1:0] PW_L = LW'(PW);

    logic [PW-1:0] hist;
    logic [PW-1:0] hist_nxt;
    logic [PW-1:0] mask;
    logic [LW-1:0] fill;
    logic [LW-1:0] fill_nxt;

    always_comb begin
        hist_nxt = {hist[PW-2:0], in};
        fill_nxt = (fill >= PW_L) ? PW_L : fill + LW'(1);
        mask     = '0;
        for (int i = 0; i < PW; i++) begin
            mask[i] = (i < int'(len));
        end
        match = shift && (fill_nxt >= len) && (((hist_nxt ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_nxt;
            // non-overlapping mode restarts the fill so the next match needs len fresh bits
            fill <= clear_fill ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Configurable serial pattern detector with hit counting and done/ack handshake.
// Define HIT_TIMESTAMP_EN to add a free-running cycle counter and the last_hit_ts output.
//
// state | meaning
// IDLE  | configurable; waits for a start with legal length
// RUN   | scanning the serial stream, counting hits
// DONE  | hit target reached; holds until ack or abort
import pattern_match_pkg::*;

module pattern_match_ctrl #(
    parameter int PW = PW_DEF,
    parameter int CW = CW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_target,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic          in,
    output logic          hit,
    output logic [CW-1:0] hit_count,
    output logic          busy,
    output logic          done,
    input  logic          ack,
    output logic          err,
`ifdef HIT_TIMESTAMP_EN
    output logic [31:0]   last_hit_ts,
`endif
    output logic [1:0]    state
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [LW-1:0] PW_L    = LW'(PW);

    state_t        state_q;
    logic [PW-1:0] pattern_r;
    logic [LW-1:0] len_r;
    logic          overlap_r;
    logic [CW-1:0] target_r;

    logic [LW-1:0] len_chk;
    logic          len_ok;
    logic          start_ok;
    logic          shift;
    logic          match;
    logic [CW-1:0] count_inc;

    assign state = state_q;

    always_comb begin
        // a same-cycle cfg write is checked before the start
        len_chk   = cfg_we ? cfg_len : len_r;
        len_ok    = (len_chk != '0) && (len_chk <= PW_L);
        start_ok  = (state_q == IDLE) && start && len_ok;
        shift     = (state_q == RUN) && in_valid && !abort;
        count_inc = (hit_count == CNT_MAX) ? hit_count : hit_count + CW'(1);
    end

    pattern_window #(
        .PW (PW),
        .LW (LW)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .shift      (shift),
        .in         (in),
        .clear      (start_ok),
        .clear_fill (match && !overlap_r),
        .len        (len_r),
        .pattern    (pattern_r),
        .match      (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hit       <= 1'b0;
            hit_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pattern_r <= '0;
            len_r     <= PW_L;
            overlap_r <= 1'b0;
            target_r  <= '0;
        end else begin
            hit <= 1'b0;
            err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_we) begin
                        pattern_r <= cfg_pattern;
                        len_r     <= cfg_len;
                        overlap_r <= cfg_overlap;
                        target_r  <= cfg_target;
                    end
                    if (start) begin
                        if (len_ok) begin
                            state_q   <= RUN;
                            busy      <= 1'b1;
                            hit_count <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else if (match) begin
                        hit       <= 1'b1;
                        hit_count <= count_inc;
                        if ((target_r != '0) && (count_inc == target_r)) begin
                            state_q <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ack || abort) begin
                        state_q <= IDLE;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef HIT_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt      <= '0;
            last_hit_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (start_ok) begin
                last_hit_ts <= '0;
            end else if (match) begin
                last_hit_ts <= ts_cnt;
            end
        end
    end
`endif

endmodule
